cnn_frame_loader: RTL and testbench

Front-end sequencer for the digit-classifier core. It accepts one 28x28 frame of signed 11-bit pixels on a valid/ready stream and writes the frame into the classifier's picture database through its we/dp/address write port. It then pulses GO, waits for the core's STOP, and captures RESULT. The captured class is returned on a valid/ready result channel, with a watchdog and error flag.

---
 rtl/cnn_loader_pkg.sv | 22 ++
 rtl/cnn_watchdog.sv | 28 ++
 rtl/cnn_frame_loader.sv | 130 +++++++++++++
 tb/tb_cnn_frame_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_loader_pkg.sv
// Shared types and constants for the CNN frame loader.
// Holds FSM states, frame geometry and error class codes.
package cnn_loader_pkg;

  typedef enum logic [2:0] {
    LOAD,
    GO_PULSE,
    WAIT_LOW,
    WAIT_HIGH,
    RESULT
  } state_t;

  function automatic int pix_n(input int edge_len);
    return edge_len * edge_len;
  endfunction

  localparam int PIX_N = pix_n(28);

  localparam logic [3:0] ERR_TIMEOUT = 4'hE;
  localparam logic [3:0] ERR_FRAME   = 4'hF;

endpackage

// File: rtl/cnn_watchdog.sv
// Clear/enable up-counter with an expiry flag.
// Expiry is only reported while counting is enabled.
module cnn_watchdog #(
  parameter int TIMEOUT_CYC = 1048576,
  parameter int CNT_W       = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && (count == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/cnn_frame_loader.sv
// Streams one frame into the classifier database, starts the
// core, waits for STOP and returns the captured class.
module cnn_frame_loader
  import cnn_loader_pkg::*;
#(
  parameter int SIZE_1           = 11,
  parameter int picture_size     = 28,
  parameter int SIZE_address_pix = 13,
  parameter int BASE_ADDR        = 0,
  parameter int TIMEOUT_CYC      = 1048576,
  parameter int CNT_W            = 21
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic signed [SIZE_1-1:0]    s_data,
  input  logic                        s_last,
  output logic                        we_database,
  output logic signed [SIZE_1-1:0]    dp_database,
  output logic [SIZE_address_pix-1:0] address_p_database,
  output logic                        GO,
  input  logic                        STOP,
  input  logic [3:0]                  RESULT,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [3:0]                  res_digit,
  output logic                        res_err,
  output logic                        busy
);

  localparam int PN   = pix_n(picture_size);
  localparam int PC_W = $clog2(PN + 1);

  state_t state, state_nx;
  logic [PC_W-1:0] pix_cnt;
  logic hs_in, hs_res, is_last;
  logic frame_err, wr_en;
  logic wd_clr, wd_en, wd_exp;

  assign hs_in     = s_valid && s_ready;
  assign hs_res    = res_valid && res_ready;
  assign is_last   = pix_cnt == PC_W'(PN - 1);
  assign frame_err = hs_in && s_last && !is_last;
  assign wr_en     = hs_in && !frame_err;
  assign wd_clr    = state == GO_PULSE;
  assign wd_en     = (state == WAIT_LOW) ||
                     (state == WAIT_HIGH);

  cnn_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(wd_exp)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD: begin
        if (frame_err)
          state_nx = cnn_loader_pkg::RESULT;
        else if (hs_in && is_last)
          state_nx = GO_PULSE;
      end
      GO_PULSE: state_nx = WAIT_LOW;
      WAIT_LOW: begin
        if (wd_exp)
          state_nx = cnn_loader_pkg::RESULT;
        else if (!STOP)
          state_nx = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (STOP || wd_exp)
          state_nx = cnn_loader_pkg::RESULT;
      end
      cnn_loader_pkg::RESULT: begin
        if (hs_res)
          state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  // GO is registered from GO_PULSE so it lands after the last write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= LOAD;
      pix_cnt            <= '0;
      s_ready            <= 1'b0;
      we_database        <= 1'b0;
      dp_database        <= '0;
      address_p_database <= SIZE_address_pix'(BASE_ADDR);
      GO                 <= 1'b0;
      res_digit          <= '0;
      res_err            <= 1'b0;
    end else begin
      state       <= state_nx;
      s_ready     <= state_nx == LOAD;
      GO          <= state == GO_PULSE;
      we_database <= wr_en;
      if (wr_en) begin
        dp_database        <= s_data;
        address_p_database <= SIZE_address_pix'(BASE_ADDR) +
                              SIZE_address_pix'(pix_cnt);
        pix_cnt            <= pix_cnt + 1'b1;
      end
      if (hs_res)
        pix_cnt <= '0;
      if (frame_err) begin
        res_digit <= ERR_FRAME;
        res_err   <= 1'b1;
      end else if (state == WAIT_HIGH && STOP) begin
        res_digit <= RESULT;
        res_err   <= 1'b0;
      end else if (wd_exp) begin
        res_digit <= ERR_TIMEOUT;
        res_err   <= 1'b1;
      end
    end
  end

  assign res_valid = state == cnn_loader_pkg::RESULT;
  assign busy      = !(state == LOAD && pix_cnt == '0);

endmodule

// File: tb/tb_cnn_frame_loader.sv
// Randomized bench for cnn_frame_loader with a cycle-level
// behavioural model and per-scenario literal expectations.
module tb_cnn_frame_loader;
  import cnn_loader_pkg::*;

  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic s_valid, s_ready, s_last;
  logic [10:0] s_data;
  logic we_database, GO, STOP;
  logic [10:0] dp_database;
  logic [12:0] address_p_database;
  logic [3:0] core_res, res_digit;
  logic res_valid, res_ready, res_err, busy;

  cnn_frame_loader #(
    .TIMEOUT_CYC(TMO),
    .CNT_W      (7)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_data            (s_data),
    .s_last            (s_last),
    .we_database       (we_database),
    .dp_database       (dp_database),
    .address_p_database(address_p_database),
    .GO                (GO),
    .STOP              (STOP),
    .RESULT            (core_res),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .res_digit         (res_digit),
    .res_err           (res_err),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Model phases: 0 load, 1 final write, 2 waiting core, 3 result
  int ph = 0, k = 0, g = 0;
  bit first = 1, mwe = 0, seen_low = 0, merr = 0;
  logic [10:0] mdp;
  logic [12:0] maddr;
  logic [3:0] mdig;
  int nwr = 0, ngo = 0, last_we_cyc = 0, go_cyc = 0;
  int first_addr = 0, last_addr = 0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_s_ready", s_ready, 0);
      chk("rst_we", we_database, 0);
      chk("rst_dp", dp_database, 0);
      chk("rst_addr", address_p_database, 0);
      chk("rst_go", GO, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_digit", res_digit, 0);
      chk("rst_res_err", res_err, 0);
      chk("rst_busy", busy, 0);
      ph = 0; k = 0; first = 1; mwe = 0;
    end else begin
      chk("s_ready", s_ready, (ph == 0 && !first));
      chk("we", we_database, mwe);
      if (mwe) begin
        chk("dp", dp_database, mdp);
        chk("addr", address_p_database, maddr);
      end
      chk("go", GO, (ph == 2 && cyc == g));
      chk("res_valid", res_valid, ph == 3);
      if (ph == 3) begin
        chk("res_digit", res_digit, mdig);
        chk("res_err", res_err, merr);
      end
      chk("busy", busy, !(ph == 0 && k == 0));
      if (we_database) begin
        if (nwr == 0) first_addr = address_p_database;
        last_addr = address_p_database;
        nwr++;
        last_we_cyc = cyc;
      end
      if (GO) begin
        ngo++;
        go_cyc = cyc;
      end
      mwe = 0;
      if (ph == 0) begin
        if (s_valid && !first) begin
          if (s_last && k < PIX_N - 1) begin
            ph = 3; mdig = 4'hF; merr = 1;
          end else begin
            mwe = 1; mdp = s_data; maddr = 13'(k);
            k++;
            if (k == PIX_N) ph = 1;
          end
        end
      end else if (ph == 1) begin
        ph = 2; g = cyc + 1; seen_low = 0;
      end else if (ph == 2) begin
        if (seen_low && STOP) begin
          ph = 3; mdig = core_res; merr = 0;
        end else if (cyc - g == TMO - 1) begin
          ph = 3; mdig = 4'hE; merr = 1;
        end else if (!seen_low && !STOP) begin
          seen_low = 1;
        end
      end else if (res_ready) begin
        ph = 0; k = 0;
      end
      first = 0;
    end
  end

  task automatic send_frame(input int n, input int last_idx,
                            input int bub, input bit rnd,
                            input int abort_at);
    bit hs;
    int tries;
    logic [10:0] dv;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) break;
      dv = rnd ? 11'($urandom) : 11'(i % 1024);
      tries = 0;
      do begin
        s_valid = ($urandom_range(99) >= bub);
        s_data = dv;
        s_last = (i == last_idx);
        @(negedge clk);
        hs = s_valid && s_ready;
        @(posedge clk);
        #1;
        tries++;
      end while (!hs && tries < 200);
      if (!hs) begin
        chk("pixel_accept", 0, 1);
        break;
      end
    end
    s_valid = 0;
    s_last = 0;
  endtask

  task automatic core(input int delay, input logic [3:0] r,
                      input bit never, output int gc);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!GO && t < 5000);
    chk("go_seen", GO, 1);
    gc = cyc;
    @(posedge clk);
    #1;
    STOP = 0;
    if (!never) begin
      repeat (delay - 1) @(posedge clk);
      #1;
      STOP = 1;
      core_res = r;
    end
  endtask

  task automatic get_result(input logic [3:0] ed, input bit ee,
                            input int hold, output int rc);
    int t = 0;
    res_ready = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!res_valid && t < 300);
    chk("res_seen", res_valid, 1);
    rc = cyc;
    chk("lit_digit", res_digit, ed);
    chk("lit_err", res_err, ee);
    repeat (hold) @(negedge clk);
    @(posedge clk);
    #1;
    res_ready = 1;
    @(posedge clk);
    #1;
    res_ready = 0;
  endtask

  task automatic clr_stats();
    nwr = 0;
    ngo = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got hang expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $fatal(1);
  end

  initial begin
    int gc, rc, d;
    logic [3:0] r;
    s_valid = 0; s_data = 0; s_last = 0;
    STOP = 0; core_res = 0; res_ready = 0;
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    clr_stats();
    send_frame(PIX_N, -1, 0, 0, -1);
    core(50, 4'd7, 0, gc);
    get_result(4'd7, 0, 0, rc);
    chk("t1_writes", nwr, 784);
    chk("t1_first_addr", first_addr, 0);
    chk("t1_last_addr", last_addr, 783);
    chk("t1_go_after_we", go_cyc - last_we_cyc, 1);
    chk("t1_go_count", ngo, 1);
    chk("t1_latency", rc - gc, 51);

    clr_stats();
    res_ready = 1;
    d = $urandom_range(40, 2);
    r = 4'($urandom_range(9));
    send_frame(PIX_N, -1, 30, 1, -1);
    core(d, r, 0, gc);
    get_result(r, 0, 20, rc);
    chk("t2_writes", nwr, 784);
    chk("t2_last_addr", last_addr, 783);
    chk("t2_latency", rc - gc, d + 1);

    clr_stats();
    send_frame(101, 100, 20, 1, -1);
    get_result(4'hF, 1, 3, rc);
    chk("t3_writes", nwr, 100);
    chk("t3_last_addr", last_addr, 99);
    chk("t3_no_go", ngo, 0);

    clr_stats();
    chk("t4_stale_stop", STOP, 1);
    send_frame(PIX_N, -1, 10, 1, -1);
    core(10, 4'd3, 0, gc);
    get_result(4'd3, 0, 2, rc);
    chk("t4_latency", rc - gc, 11);

    clr_stats();
    send_frame(PIX_N, -1, 0, 1, -1);
    core(0, 4'd0, 1, gc);
    get_result(4'hE, 1, 1, rc);
    chk("t5_timeout_cycles", rc - gc, 64);

    send_frame(PIX_N, -1, 10, 1, 400);
    chk("t6_pre_rst_we", we_database, 1);
    #2 rst = 1;
    #1;
    chk("t6_async_we", we_database, 0);
    chk("t6_async_ready", s_ready, 0);
    chk("t6_async_addr", address_p_database, 0);
    chk("t6_async_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    clr_stats();
    r = 4'($urandom_range(9));
    send_frame(PIX_N, -1, 15, 1, -1);
    core(20, r, 0, gc);
    get_result(r, 0, 0, rc);
    chk("t6_writes", nwr, 784);
    chk("t6_first_addr", first_addr, 0);
    chk("t6_go_count", ngo, 1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
